// File: rtl/frame_norm_pkg.sv
// Shared definitions for frame_normalize: FSM state encoding and the capped
// leading-zero count used to pick the per-frame block exponent.
package frame_norm_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int CLZ_MAX_W = 64;

    // Leading zeros of the low 'width' bits of vec; an all-zero field returns width.
    function automatic int clz(input logic [CLZ_MAX_W-1:0] vec, input int width);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        for (int i = CLZ_MAX_W - 1; i >= 0; i--) begin
            if ((i < width) && !found) begin
                if (vec[i]) begin
                    found = 1'b1;
                end else begin
                    n++;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/frame_normalize_sdp_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port,
// no reset on the storage array.
module sdp_ram #(
    parameter  int W     = 16,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/frame_normalize.sv
// Block-floating-point input normaliser: buffers N samples, then replays them
// widened and left-justified. Define FRAME_NORM_EXP_EN for per-frame exponent and o_exp.
module frame_normalize
    import frame_norm_pkg::*;
#(
    parameter int W_IN  = 16,
    parameter int W_OUT = 32,
    parameter int N     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_IN-1:0]   i_data,
    input  logic              i_vld,
    output logic              i_rdy,
    output logic [W_OUT-1:0]  o_data,
    output logic              o_vld,
    output logic              o_last,
    output logic              o_drop
`ifdef FRAME_NORM_EXP_EN
    ,output logic [$clog2(W_IN)-1:0] o_exp
`endif
);

    localparam int AW  = $clog2(N);
    localparam int EW  = $clog2(W_IN);
    localparam int SHW = $clog2(W_OUT);

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     wr_cnt;
    logic [AW-1:0]     rd_cnt;
    logic [AW-1:0]     rd_addr;
    logic [W_IN-1:0]   rd_data;
    logic [EW-1:0]     r;
    logic              accept;
    logic              last_accept;
    logic              last_read;
    logic [W_OUT-1:0]  ext;
    logic [SHW-1:0]    shamt;

    assign accept      = (state == FILL) && i_vld;
    assign last_accept = accept && (wr_cnt == AW'(N - 1));
    assign last_read   = (state == DRAIN) && (rd_cnt == AW'(N - 1));
    assign i_rdy       = (state == FILL);

    // rd_data must already hold buffer[rd_cnt] in each DRAIN cycle, so the
    // read address runs one ahead; address 0 is pre-read while filling.
    assign rd_addr = (state == DRAIN) ? (rd_cnt + AW'(1)) : '0;

    sdp_ram #(
        .W     (W_IN),
        .DEPTH (N)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_cnt),
        .wr_data (i_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:  if (last_accept) state_next = DRAIN;
            DRAIN: if (last_read)   state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (accept) begin
                wr_cnt <= last_accept ? '0 : (wr_cnt + AW'(1));
            end
            if (state == DRAIN) begin
                rd_cnt <= last_read ? '0 : (rd_cnt + AW'(1));
            end
        end
    end

`ifdef FRAME_NORM_EXP_EN
    // acc collects every bit that differs from its sample's sign bit.
    logic [W_IN-2:0] acc;
    logic [W_IN-2:0] acc_next;

    assign acc_next = acc | (i_data[W_IN-2:0] ^ {(W_IN-1){i_data[W_IN-1]}});

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
            r   <= '0;
        end else if (accept) begin
            acc <= last_accept ? '0 : acc_next;
            if (last_accept) begin
                r <= EW'(clz(CLZ_MAX_W'(acc_next), W_IN - 1));
            end
        end
    end

    assign o_exp = r;
`else
    assign r = '0;
`endif

    assign ext   = {{(W_OUT-W_IN){rd_data[W_IN-1]}}, rd_data};
    assign shamt = SHW'(W_OUT - W_IN) + SHW'(r);

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_data <= '0;
            o_vld  <= 1'b0;
            o_last <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            o_vld  <= (state == DRAIN);
            o_last <= last_read;
            o_data <= (state == DRAIN) ? (ext << shamt) : '0;
            o_drop <= i_vld && (state != FILL);
        end
    end

endmodule

// File: tb/tb_frame_normalize.sv
// Directed self-checking bench for frame_normalize with N=8, W_IN=16, W_OUT=32;
// expectations follow FRAME_NORM_EXP_EN when it is defined for the build.
module tb_frame_normalize;

`ifdef FRAME_NORM_EXP_EN
    localparam bit EXP_EN = 1'b1;
`else
    localparam bit EXP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_data;
    logic        i_vld;
    logic        i_rdy;
    logic [31:0] o_data;
    logic        o_vld;
    logic        o_last;
    logic        o_drop;
`ifdef FRAME_NORM_EXP_EN
    logic [3:0]  o_exp;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] frame_q [8];

    always #5 clk = ~clk;

    frame_normalize #(
        .W_IN  (16),
        .W_OUT (32),
        .N     (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_data (i_data),
        .i_vld  (i_vld),
        .i_rdy  (i_rdy),
        .o_data (o_data),
        .o_vld  (o_vld),
        .o_last (o_last),
        .o_drop (o_drop)
`ifdef FRAME_NORM_EXP_EN
        ,.o_exp (o_exp)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feeds frame_q back to back; returns one cycle after the last accept.
    task automatic drive_frame();
        for (int i = 0; i < 8; i++) begin
            i_data = frame_q[i];
            i_vld  = 1'b1;
            step();
        end
        i_vld  = 1'b0;
        i_data = '0;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        i_vld  = 1'b1;
        i_data = 16'h1234;
        step();
        step();
        checks++;
        if (o_vld !== 1'b0 || o_last !== 1'b0 || o_drop !== 1'b0 || o_data !== 32'h0 || i_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state got vld=%b last=%b drop=%b data=%h rdy=%b want 0 0 0 00000000 1",
                     o_vld, o_last, o_drop, o_data, i_rdy);
        end
`ifdef FRAME_NORM_EXP_EN
        checks++;
        if (o_exp !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_exp got %0d want 0", o_exp);
        end
`endif
        rst    = 1'b1;
        i_vld  = 1'b0;
        i_data = '0;
        step();
    endtask

    task automatic test_ones();
        logic [31:0] want;
        want = EXP_EN ? 32'h4000_0000 : 32'h0001_0000;
        for (int i = 0; i < 8; i++) frame_q[i] = 16'h0001;
        drive_frame();
        checks++;
        if (i_rdy !== 1'b0 || o_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ones_t1 got rdy=%b vld=%b want 0 0", i_rdy, o_vld);
        end
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_vld !== 1'b1 || o_data !== want || o_last !== (k == 7)) begin
                errors++;
                $display("[TB] FAIL ones_out[%0d] got vld=%b data=%h last=%b want 1 %h %b",
                         k, o_vld, o_data, o_last, want, (k == 7));
            end
`ifdef FRAME_NORM_EXP_EN
            checks++;
            if (o_exp !== 4'd14) begin
                errors++;
                $display("[TB] FAIL ones_exp[%0d] got %0d want 14", k, o_exp);
            end
`endif
            if (k == 7) begin
                checks++;
                if (i_rdy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL ones_rdy_back got %b want 1", i_rdy);
                end
            end
            step();
        end
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ones_after got vld=%b want 0", o_vld);
        end
    endtask

    task automatic test_single_max();
        logic [31:0] want;
        frame_q[0] = 16'h8000;
        for (int i = 1; i < 8; i++) frame_q[i] = 16'h0000;
        drive_frame();
        step();
        for (int k = 0; k < 8; k++) begin
            want = (k == 0) ? 32'h8000_0000 : 32'h0000_0000;
            checks++;
            if (o_vld !== 1'b1 || o_data !== want || o_last !== (k == 7)) begin
                errors++;
                $display("[TB] FAIL max_out[%0d] got vld=%b data=%h last=%b want 1 %h %b",
                         k, o_vld, o_data, o_last, want, (k == 7));
            end
`ifdef FRAME_NORM_EXP_EN
            checks++;
            if (o_exp !== 4'd0) begin
                errors++;
                $display("[TB] FAIL max_exp[%0d] got %0d want 0", k, o_exp);
            end
`endif
            step();
        end
    endtask

    task automatic test_zero();
        for (int i = 0; i < 8; i++) frame_q[i] = 16'h0000;
        drive_frame();
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_vld !== 1'b1 || o_data !== 32'h0 || o_last !== (k == 7)) begin
                errors++;
                $display("[TB] FAIL zero_out[%0d] got vld=%b data=%h last=%b want 1 00000000 %b",
                         k, o_vld, o_data, o_last, (k == 7));
            end
`ifdef FRAME_NORM_EXP_EN
            checks++;
            if (o_exp !== 4'd15) begin
                errors++;
                $display("[TB] FAIL zero_exp[%0d] got %0d want 15", k, o_exp);
            end
`endif
            step();
        end
    endtask

    task automatic test_minus_one();
        logic [31:0] want;
        want = EXP_EN ? 32'h8000_0000 : 32'hFFFF_0000;
        for (int i = 0; i < 8; i++) frame_q[i] = 16'hFFFF;
        drive_frame();
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_vld !== 1'b1 || o_data !== want || o_last !== (k == 7)) begin
                errors++;
                $display("[TB] FAIL m1_out[%0d] got vld=%b data=%h last=%b want 1 %h %b",
                         k, o_vld, o_data, o_last, want, (k == 7));
            end
`ifdef FRAME_NORM_EXP_EN
            checks++;
            if (o_exp !== 4'd15) begin
                errors++;
                $display("[TB] FAIL m1_exp[%0d] got %0d want 15", k, o_exp);
            end
`endif
            step();
        end
    endtask

    // i_vld held high for 24 cycles: frame A accepted, 8 drops during its
    // drain, frame B starts on A's o_last cycle and completes afterwards.
    task automatic test_back_to_back();
        int          sh;
        logic        want_vld;
        logic        want_last;
        logic        want_drop;
        logic        want_rdy;
        logic [31:0] want_data;
        sh = EXP_EN ? 22 : 16;
        for (int j = 0; j < 34; j++) begin
            want_vld  = (j >= 9 && j <= 16) || (j >= 25 && j <= 32);
            want_last = (j == 16) || (j == 32);
            want_drop = (j >= 9 && j <= 16);
            want_rdy  = (j <= 7) || (j >= 16 && j <= 23) || (j >= 32);
            if (j >= 9 && j <= 16) begin
                want_data = (32'h100 + 32'(j - 9)) << sh;
            end else if (j >= 25 && j <= 32) begin
                want_data = (32'h110 + 32'(j - 25)) << sh;
            end else begin
                want_data = 32'h0;
            end
            checks++;
            if (o_vld !== want_vld || o_last !== want_last || o_drop !== want_drop || i_rdy !== want_rdy) begin
                errors++;
                $display("[TB] FAIL b2b_ctrl[%0d] got vld=%b last=%b drop=%b rdy=%b want %b %b %b %b",
                         j, o_vld, o_last, o_drop, i_rdy, want_vld, want_last, want_drop, want_rdy);
            end
            if (want_vld) begin
                checks++;
                if (o_data !== want_data) begin
                    errors++;
                    $display("[TB] FAIL b2b_data[%0d] got %h want %h", j, o_data, want_data);
                end
`ifdef FRAME_NORM_EXP_EN
                checks++;
                if (o_exp !== 4'd6) begin
                    errors++;
                    $display("[TB] FAIL b2b_exp[%0d] got %0d want 6", j, o_exp);
                end
`endif
            end
            i_vld  = (j < 24);
            i_data = (j >= 8 && j < 16) ? 16'h7FFF : (16'h0100 + 16'(j));
            step();
        end
        i_vld  = 1'b0;
        i_data = '0;
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] want;
        want = EXP_EN ? 32'h4000_0000 : 32'h0100_0000;
        for (int i = 0; i < 8; i++) frame_q[i] = 16'h1234;
        drive_frame();
        step();
        step();
        step();
        checks++;
        if (o_vld !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_pre got vld=%b want 1", o_vld);
        end
        rst = 1'b0;
        step();
        checks++;
        if (o_vld !== 1'b0 || i_rdy !== 1'b1 || o_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid got vld=%b rdy=%b last=%b want 0 1 0", o_vld, i_rdy, o_last);
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) frame_q[i] = 16'h0100;
        drive_frame();
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_stale got vld=%b want 0", o_vld);
        end
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_vld !== 1'b1 || o_data !== want || o_last !== (k == 7)) begin
                errors++;
                $display("[TB] FAIL rst_out[%0d] got vld=%b data=%h last=%b want 1 %h %b",
                         k, o_vld, o_data, o_last, want, (k == 7));
            end
`ifdef FRAME_NORM_EXP_EN
            checks++;
            if (o_exp !== 4'd6) begin
                errors++;
                $display("[TB] FAIL rst_exp[%0d] got %0d want 6", k, o_exp);
            end
`endif
            step();
        end
    endtask

    initial begin
        rst    = 1'b0;
        i_vld  = 1'b0;
        i_data = '0;
        test_reset();
        test_ones();
        test_single_max();
        test_zero();
        test_minus_one();
        test_back_to_back();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
